// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, memory write encoding, FSM states.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      WE_NONE = 2'b00,
      WE_WORD = 2'b01,
      WE_BYTE = 2'b11
   } mem_we_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SH_HI = 1'b1
   } lsu_state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load data extension selected by RISC-V funct3; unknown codes yield zero.
module load_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] rdata,
   output logic [31:0] ext
);

   always_comb begin
      ext = 32'h0;
      case (funct3)
         F3_LB:   ext = {{24{rdata[7]}}, rdata[7:0]};
         F3_LH:   ext = {{16{rdata[15]}}, rdata[15:0]};
         F3_LW:   ext = rdata;
         F3_LBU:  ext = {24'h0, rdata[7:0]};
         F3_LHU:  ext = {16'h0, rdata[15:0]};
         default: ext = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a byte/word-write data memory; SH is split into two byte writes.
// Optional macro LSU_MISALIGN_TRAP_EN adds a misalign output and suppresses misaligned accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  stall,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic                  misalign,
`endif
   output logic [1:0]            mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wd,
   input  logic [DATA_WIDTH-1:0] mem_rd
);

   lsu_state_e            state_q;
   logic [ADDR_WIDTH-1:0] hi_addr_q;
   logic [7:0]            hi_byte_q;
   logic                  resp_valid_q;
   logic [DATA_WIDTH-1:0] resp_rdata_q;
   logic [DATA_WIDTH-1:0] ext_data;
   logic                  accept;
   logic                  misaligned;
   mem_we_e               we;

   load_extend u_load_extend (
      .funct3 (req_funct3),
      .rdata  (mem_rd),
      .ext    (ext_data)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign_q;
   assign misalign = misalign_q;

   // Funct3 101 is only a halfword for loads; as a store it is simply invalid.
   always_comb begin
      misaligned = 1'b0;
      if ((req_funct3 == F3_LH || (!req_store && req_funct3 == F3_LHU)) && req_addr[0]) begin
         misaligned = 1'b1;
      end else if (req_funct3 == F3_LW && req_addr[1:0] != 2'b00) begin
         misaligned = 1'b1;
      end
   end
`else
   assign misaligned = 1'b0;
`endif

   assign req_ready  = !rst && (state_q == IDLE);
   assign accept     = req_valid && req_ready;
   assign stall      = (state_q == SH_HI);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_we     = we;
   assign mem_addr   = (state_q == SH_HI) ? hi_addr_q : req_addr;
   assign mem_wd     = (state_q == SH_HI) ? {{(DATA_WIDTH-8){1'b0}}, hi_byte_q} : req_wdata;

   // Reset masks the write strobe so an in-flight SH high byte is dropped.
   always_comb begin
      we = WE_NONE;
      if (rst) begin
         we = WE_NONE;
      end else if (state_q == SH_HI) begin
         we = WE_BYTE;
      end else if (accept && req_store && !misaligned) begin
         case (req_funct3)
            F3_SB, F3_SH: we = WE_BYTE;
            F3_SW:        we = WE_WORD;
            default:      we = WE_NONE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hi_addr_q    <= '0;
         hi_byte_q    <= 8'h00;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         resp_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_q   <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (req_store && req_funct3 == F3_SH && !misaligned) begin
                     hi_addr_q <= req_addr + ADDR_WIDTH'(1);
                     hi_byte_q <= req_wdata[15:8];
                     state_q   <= SH_HI;
                  end else begin
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= (req_store || misaligned) ? '0 : ext_data;
`ifdef LSU_MISALIGN_TRAP_EN
                     misalign_q   <= misaligned;
`endif
                  end
               end
            end
            SH_HI: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 1 KiB byte memory model.
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        stall;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        misalign;
`endif
   logic [1:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [7:0]  mem [0:1023];
   logic        mem_clr;
   logic [9:0]  a0, a1, a2, a3;
   int          errs;
   int          checks;

   load_store_unit #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .stall      (stall),
`ifdef LSU_MISALIGN_TRAP_EN
      .misalign   (misalign),
`endif
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model indexed by the low 10 address bits.
   always_comb begin
      a0 = mem_addr[9:0];
      a1 = mem_addr[9:0] + 10'd1;
      a2 = mem_addr[9:0] + 10'd2;
      a3 = mem_addr[9:0] + 10'd3;
      mem_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};
   end

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      end else if (mem_we == 2'b01) begin
         mem[a0] <= mem_wd[7:0];
         mem[a1] <= mem_wd[15:8];
         mem[a2] <= mem_wd[23:16];
         mem[a3] <= mem_wd[31:24];
      end else if (mem_we == 2'b11) begin
         mem[a0] <= mem_wd[7:0];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      step();
      drive(1'b1, f3, addr, wd);
      step();
      req_valid = 1'b0;
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp,
                          input string name);
      step();
      drive(1'b0, f3, addr, 32'h0);
      step();
      req_valid = 1'b0;
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp) begin
         errs++;
         $display("FAIL %s: valid=%b rdata=%h, want valid=1 rdata=%h", name, resp_valid,
                  resp_rdata, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_clr = 1'b1;
      drive(1'b1, 3'b010, 32'h0001_0000, 32'h1234_5678);
      step();
      step();
      checks++;
      if (mem_we !== 2'b00 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
         errs++;
         $display("FAIL reset_outputs: we=%b valid=%b ready=%b, want 00 0 0", mem_we, resp_valid,
                  req_ready);
      end
      rst = 1'b0;
      mem_clr = 1'b0;
      req_valid = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || stall !== 1'b0) begin
         errs++;
         $display("FAIL reset_release: ready=%b stall=%b, want 1 0", req_ready, stall);
      end
   endtask

   task automatic test_idle();
      step();
      #1;
      checks++;
      if (mem_we !== 2'b00 || resp_valid !== 1'b0) begin
         errs++;
         $display("FAIL idle_no_req: we=%b valid=%b, want 00 0", mem_we, resp_valid);
      end
   endtask

   task automatic test_back_to_back();
      step();
      drive(1'b1, 3'b010, 32'h0001_0000, 32'hDEAD_BEEF);
      #1;
      checks++;
      if (mem_we !== 2'b01 || mem_addr !== 32'h0001_0000 || mem_wd !== 32'hDEAD_BEEF) begin
         errs++;
         $display("FAIL sw_drive: we=%b addr=%h wd=%h, want 01 00010000 deadbeef", mem_we,
                  mem_addr, mem_wd);
      end
      step();
      drive(1'b0, 3'b010, 32'h0001_0000, 32'h0);
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || mem_we !== 2'b00 || req_ready !== 1'b1)
      begin
         errs++;
         $display("FAIL sw_resp: valid=%b rdata=%h we=%b ready=%b, want 1 0 00 1", resp_valid,
                  resp_rdata, mem_we, req_ready);
      end
      step();
      req_valid = 1'b0;
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin
         errs++;
         $display("FAIL lw_resp: valid=%b rdata=%h, want 1 deadbeef", resp_valid, resp_rdata);
      end
      step();
      checks++;
      if (resp_valid !== 1'b0) begin
         errs++;
         $display("FAIL resp_pulse: valid=%b, want 0", resp_valid);
      end
   endtask

   task automatic test_load_extend();
      do_store(3'b010, 32'h0001_0004, 32'h8001_0080);
      do_load(3'b000, 32'h0001_0004, 32'hFFFF_FF80, "lb");
      do_load(3'b100, 32'h0001_0004, 32'h0000_0080, "lbu");
      do_load(3'b001, 32'h0001_0006, 32'hFFFF_8001, "lh");
      do_load(3'b101, 32'h0001_0006, 32'h0000_8001, "lhu");
      do_load(3'b011, 32'h0001_0004, 32'h0000_0000, "load_bad_f3");
      // SB must only touch the low byte
      do_store(3'b000, 32'h0001_0008, 32'h1234_56C7);
      do_load(3'b010, 32'h0001_0008, 32'h0000_00C7, "sb_word");
      step();
      drive(1'b1, 3'b111, 32'h0001_000C, 32'hFFFF_FFFF);
      #1;
      checks++;
      if (mem_we !== 2'b00) begin
         errs++;
         $display("FAIL store_bad_f3_we: we=%b, want 00", mem_we);
      end
      step();
      req_valid = 1'b0;
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || mem[10'h00C] !== 8'h00) begin
         errs++;
         $display("FAIL store_bad_f3_resp: valid=%b rdata=%h mem=%h, want 1 0 00", resp_valid,
                  resp_rdata, mem[10'h00C]);
      end
   endtask

   task automatic test_sh_split();
      step();
      drive(1'b1, 3'b001, 32'h0001_0010, 32'h0000_A5B6);
      #1;
      checks++;
      if (mem_we !== 2'b11 || mem_addr !== 32'h0001_0010 || mem_wd[7:0] !== 8'hB6 ||
          stall !== 1'b0) begin
         errs++;
         $display("FAIL sh_cycle0: we=%b addr=%h wd=%h stall=%b, want 11 00010010 b6 0", mem_we,
                  mem_addr, mem_wd[7:0], stall);
      end
      step();
      // Offer a new SW while stalled; it must be ignored.
      drive(1'b1, 3'b010, 32'h0001_0020, 32'hFFFF_FFFF);
      #1;
      checks++;
      if (stall !== 1'b1 || req_ready !== 1'b0 || mem_we !== 2'b11 ||
          mem_addr !== 32'h0001_0011 || mem_wd !== 32'h0000_00A5 || resp_valid !== 1'b0) begin
         errs++;
         $display("FAIL sh_cycle1: stall=%b ready=%b we=%b addr=%h wd=%h valid=%b, want 1 0 11 00010011 000000a5 0",
                  stall, req_ready, mem_we, mem_addr, mem_wd, resp_valid);
      end
      step();
      req_valid = 1'b0;
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || stall !== 1'b0 ||
          mem[10'h020] !== 8'h00) begin
         errs++;
         $display("FAIL sh_done: valid=%b rdata=%h stall=%b mem20=%h, want 1 0 0 00", resp_valid,
                  resp_rdata, stall, mem[10'h020]);
      end
      do_load(3'b101, 32'h0001_0010, 32'h0000_A5B6, "sh_lhu");
   endtask

   task automatic test_sh_reset();
      do_store(3'b000, 32'h0001_0031, 32'h0000_005A);
      step();
      drive(1'b1, 3'b001, 32'h0001_0030, 32'h0000_C3D4);
      step();
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (mem_we !== 2'b00 || stall !== 1'b1) begin
         errs++;
         $display("FAIL shrst_mask: we=%b stall=%b, want 00 1", mem_we, stall);
      end
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || stall !== 1'b0 || req_ready !== 1'b1 ||
          mem[10'h031] !== 8'h5A || mem[10'h030] !== 8'hD4) begin
         errs++;
         $display("FAIL shrst_state: valid=%b stall=%b ready=%b m31=%h m30=%h, want 0 0 1 5a d4",
                  resp_valid, stall, req_ready, mem[10'h031], mem[10'h030]);
      end
      step();
      checks++;
      if (resp_valid !== 1'b0) begin
         errs++;
         $display("FAIL shrst_noresp: valid=%b, want 0", resp_valid);
      end
   endtask

`ifdef LSU_MISALIGN_TRAP_EN
   task automatic test_misalign();
      step();
      drive(1'b1, 3'b010, 32'h0001_0002, 32'h1122_3344);
      #1;
      checks++;
      if (mem_we !== 2'b00) begin
         errs++;
         $display("FAIL mis_sw_we: we=%b, want 00", mem_we);
      end
      step();
      drive(1'b1, 3'b001, 32'h0001_0041, 32'h0000_7788);
      #1;
      checks++;
      if (misalign !== 1'b1 || resp_valid !== 1'b1 || resp_rdata !== 32'h0 ||
          mem[10'h002] !== 8'h00 || mem_we !== 2'b00) begin
         errs++;
         $display("FAIL mis_sw_resp: mis=%b valid=%b rdata=%h mem2=%h we=%b, want 1 1 0 00 00",
                  misalign, resp_valid, resp_rdata, mem[10'h002], mem_we);
      end
      step();
      req_valid = 1'b0;
      #1;
      checks++;
      if (misalign !== 1'b1 || resp_valid !== 1'b1 || stall !== 1'b0 || mem[10'h041] !== 8'h00)
      begin
         errs++;
         $display("FAIL mis_sh_resp: mis=%b valid=%b stall=%b mem41=%h, want 1 1 0 00", misalign,
                  resp_valid, stall, mem[10'h041]);
      end
      do_load(3'b010, 32'h0001_0004, 32'h8001_0080, "aligned_lw");
      checks++;
      if (misalign !== 1'b0) begin
         errs++;
         $display("FAIL mis_clear: mis=%b, want 0", misalign);
      end
   endtask
`else
   task automatic test_wrap();
      step();
      drive(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_7788);
      #1;
      checks++;
      if (mem_addr !== 32'hFFFF_FFFF || mem_we !== 2'b11) begin
         errs++;
         $display("FAIL wrap_lo: addr=%h we=%b, want ffffffff 11", mem_addr, mem_we);
      end
      step();
      req_valid = 1'b0;
      #1;
      checks++;
      if (mem_addr !== 32'h0 || mem_wd !== 32'h0000_0077) begin
         errs++;
         $display("FAIL wrap_hi: addr=%h wd=%h, want 00000000 00000077", mem_addr, mem_wd);
      end
      step();
      checks++;
      if (resp_valid !== 1'b1 || mem[10'h3FF] !== 8'h88 || mem[10'h000] !== 8'h77) begin
         errs++;
         $display("FAIL wrap_mem: valid=%b m3ff=%h m0=%h, want 1 88 77", resp_valid,
                  mem[10'h3FF], mem[10'h000]);
      end
      do_load(3'b101, 32'h0001_0011, 32'h0000_00A5, "misaligned_lhu");
   endtask
`endif

   initial begin
      errs       = 0;
      checks     = 0;
      rst        = 1'b1;
      mem_clr    = 1'b1;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      test_reset();
      test_idle();
      test_back_to_back();
      test_load_extend();
      test_sh_split();
      test_sh_reset();
`ifdef LSU_MISALIGN_TRAP_EN
      test_misalign();
`else
      test_wrap();
`endif
      step();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
